// File: rtl/gcd_result_buffer.sv
// gcd_result_buffer: output stage of the GCD engine. Each finished result is
// tagged with a wrapping sequence number and queued in a small FIFO, so a slow
// consumer never stalls the GCD FSM. Results that arrive while the FIFO is full
// are dropped and a sticky overflow flag is raised.
module gcd_result_buffer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     res_valid,
    input  logic [W-1:0]             res_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TAG_W-1:0]  seq_tag_q, seq_tag_d;
    logic              ovf_q, ovf_d;

    logic              pop, push, drop;
    logic              full_w, empty_w;
    entry_t            head;

    // Status is decoded from the registered count only.
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    assign pop  = ~empty_w & out_ready;
    // A full FIFO may still accept a result when the head leaves this cycle.
    assign push = res_valid & (~full_w | pop);
    assign drop = res_valid & full_w & ~pop;

    // Head is masked while empty so outputs read zero out of reset.
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = ~empty_w;
    assign out_data  = empty_w ? '0 : head.data;
    assign out_tag   = empty_w ? '0 : head.tag;
    assign count     = count_q;
    assign full      = full_w;
    assign overflow  = ovf_q;

    // Next-state for pointers, occupancy, sequence tag and overflow flag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        seq_tag_d = seq_tag_q;
        ovf_d     = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Dropped results still consume a tag so the consumer sees the gap.
        if (res_valid) seq_tag_d = seq_tag_q + TAG_W'(1);

        // Set beats clear when both happen together.
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            seq_tag_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            seq_tag_q <= seq_tag_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage array: no reset needed, entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{data: res_data, tag: seq_tag_q};
    end

endmodule

// File: tb/tb_gcd_result_buffer.sv
// Self-checking bench for gcd_result_buffer: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_gcd_result_buffer;

    localparam int W = 16, DEPTH = 4, TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             res_valid = 1'b0;
    logic [W-1:0]     res_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       count;
    logic             full;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    gcd_result_buffer #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .count(count), .full(full), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     d;
        logic [TAG_W-1:0] t;
    } ent_t;

    ent_t q[$];
    int   mtag = 0;
    bit   movf = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    // Compare every observable output against the model.
    task automatic chk_model();
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("valid", out_valid, q.size() != 0);
        chk("ovf", overflow, movf);
        if (q.size() != 0) begin
            chk("data", out_data, q[0].d);
            chk("tag", out_tag, q[0].t);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check after edge.
    task automatic step(input bit rv, input logic [W-1:0] d, input bit rdy, input bit clr);
        bit was_full, do_pop;
        @(negedge clk);
        res_valid = rv; res_data = d; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        was_full = (q.size() == DEPTH);
        do_pop   = (q.size() != 0) && rdy;
        if (do_pop) void'(q.pop_front());
        if (clr) movf = 0;
        if (rv) begin
            if (!was_full || do_pop) q.push_back('{d: d, t: TAG_W'(mtag)});
            else movf = 1;
            mtag = (mtag + 1) % (1 << TAG_W);
        end
        #1;
        chk_model();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk); reset = 1'b1;

        // Three results with consumer stalled
        step(1, 16'd12, 0, 0);
        step(1, 16'd5, 0, 0);
        step(1, 16'd7, 0, 0);
        chk("t1_count", count, 3);
        chk("t1_data", out_data, 12);
        chk("t1_tag", out_tag, 0);
        chk("t1_full", full, 0);

        // Fill, then one more is dropped
        step(1, 16'd9, 0, 0);
        step(1, 16'd3, 0, 0);
        chk("t2_full", full, 1);
        chk("t2_ovf", overflow, 1);
        chk("t2_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_tag", out_tag, i);
            step(0, 0, 1, 0);
        end
        step(1, 16'd21, 0, 0);
        chk("t2_gap_tag", out_tag, 5);
        step(0, 0, 0, 1);
        chk("t2_clr", overflow, 0);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 3; i++) step(1, W'($urandom), 0, 0);
        step(1, 16'hbeef, 1, 0);
        chk("t3_count", count, 4);
        chk("t3_ovf", overflow, 0);

        // Drop and clear together: set wins
        step(1, 16'h1111, 0, 1);
        chk("t5_set_wins", overflow, 1);
        step(0, 0, 0, 1);
        chk("t5_clear", overflow, 0);

        // Drain, then streaming with consumer always ready
        while (q.size() != 0) step(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, W'($urandom), 1, 0);
            chk("t4_cnt_le1", count <= 1, 1);
        end
        step(0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 60, W'($urandom),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8);

        // Asynchronous reset mid-handshake
        while (q.size() != 0) step(0, 0, 1, 0);
        step(1, 16'd40, 0, 0);
        step(1, 16'd41, 0, 0);
        chk("t6_pre_count", count, 2);
        @(negedge clk);
        out_ready = 1'b1; res_valid = 1'b0; clr_ovf = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_full", full, 0);
        q.delete(); mtag = 0; movf = 0;
        @(negedge clk); reset = 1'b1;
        step(1, 16'd77, 0, 0);
        chk("t6_tag0", out_tag, 0);
        chk("t6_data", out_data, 77);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
